// File: rtl/diwall_pkg.sv
// Shared types and helpers for the Diwall RSSI anomaly decision stage.
// Sign-magnitude samples are widened to 33-bit two's complement so -0 and +0 compare equal.
package diwall_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        UPD  = 2'd2
    } dec_state_t;

    localparam logic [30:0] SM_MAG_MAX = 31'h7FFF_FFFF;

    function automatic logic signed [32:0] sm_to_tc(input logic [31:0] sm);
        logic signed [32:0] mag;
        mag = $signed({2'b00, sm[30:0]});
        return sm[31] ? -mag : mag;
    endfunction

endpackage

// File: rtl/sm_abs_diff.sv
// Combinational sign-magnitude subtractor: diff_o = a_i - b_i, magnitude saturated to 31 bits.
// A zero result is always reported as +0.
module sm_abs_diff
    import diwall_pkg::*;
(
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic [31:0] diff_o
);

    logic signed [32:0] a_tc;
    logic signed [32:0] b_tc;
    logic        [33:0] diff;
    logic        [33:0] mag;
    logic               sat;

    always_comb begin
        a_tc = sm_to_tc(a_i);
        b_tc = sm_to_tc(b_i);
        // One extra bit keeps the full range of the difference of two 33-bit values.
        diff = {a_tc[32], a_tc} - {b_tc[32], b_tc};
        mag  = diff[33] ? (~diff + 34'd1) : diff;
        sat  = (mag > {3'b000, SM_MAG_MAX});
        diff_o = {diff[33], sat ? SM_MAG_MAX : mag[30:0]};
    end

endmodule

// File: rtl/rssi_anomaly_decision.sv
// Classifies each RSSI sample against the previous EWMA baseline and drives a hysteretic
// jamming/spoofing alarm. Decision results appear combinationally in the UPD cycle (N+2).
module rssi_anomaly_decision
    import diwall_pkg::*;
#(
    parameter logic [30:0] DEV_THRESH  = 31'd20,
    parameter int unsigned ALARM_COUNT = 3,
    parameter int unsigned CLEAR_COUNT = 8,
    parameter int unsigned WARMUP      = 4
) (
    input  logic        clk_h,
    input  logic        rst_h,
    input  logic        sample_valid,
    input  logic [31:0] rssi,
    input  logic        EnableDecision,
    input  logic [31:0] ewma_rssi,
    input  logic        clear,
    output logic        decision_valid,
    output logic        outlier,
    output logic [31:0] deviation,
    output logic        alarm,
    output logic        alarm_pulse,
    output logic [15:0] alarm_total,
    output logic        overrun
);

    localparam int unsigned OW = $clog2(ALARM_COUNT + 1);
    localparam int unsigned IW = $clog2(CLEAR_COUNT + 1);
    localparam int unsigned WW = $clog2(WARMUP + 2);
    localparam logic [OW-1:0] OUT_SAT  = OW'(ALARM_COUNT);
    localparam logic [IW-1:0] IN_SAT   = IW'(CLEAR_COUNT);
    localparam logic [WW-1:0] WARM_SAT = WW'(WARMUP);

    dec_state_t    state_q, state_d;
    logic [31:0]   sample_q, sample_d;
    logic          have_sample_q, have_sample_d;
    logic [31:0]   ewma_q, ewma_d;
    logic [31:0]   snap_q, snap_d;
    logic          snap_ok_q, snap_ok_d;
    logic [31:0]   baseline_q, baseline_d;
    logic [31:0]   dev_q, dev_d;
    logic [WW-1:0] warm_q, warm_d;
    logic [OW-1:0] out_run_q, out_run_d;
    logic [IW-1:0] in_run_q, in_run_d;
    logic          alarm_q, alarm_d;
    logic [15:0]   total_q, total_d;
    logic          overrun_q, overrun_d;
    logic          outlier_q, outlier_d;
    logic [31:0]   deviation_q, deviation_d;

    logic [31:0]   diff_w;
    logic          warm_done;
    logic          dec_now;
    logic          upd_outlier;
    logic [OW-1:0] upd_out_run;
    logic [IW-1:0] upd_in_run;
    logic          upd_alarm;
    logic          upd_rise;
    logic [15:0]   upd_total;

    sm_abs_diff u_diff (
        .a_i    (snap_q),
        .b_i    (baseline_q),
        .diff_o (diff_w)
    );

    assign warm_done = (warm_q >= WARM_SAT);
    assign dec_now   = (state_q == UPD) && warm_done && snap_ok_q;

    // Classification result of the decision sitting in dev_q, computed from registers only.
    always_comb begin
        upd_outlier = (dev_q[30:0] > DEV_THRESH);
        upd_out_run = '0;
        upd_in_run  = '0;
        upd_alarm   = alarm_q;
        if (upd_outlier) begin
            upd_out_run = (out_run_q >= OUT_SAT) ? OUT_SAT : out_run_q + OW'(1);
            upd_alarm   = alarm_q | (upd_out_run == OUT_SAT);
        end else begin
            upd_in_run = (in_run_q >= IN_SAT) ? IN_SAT : in_run_q + IW'(1);
            upd_alarm  = alarm_q & (upd_in_run != IN_SAT);
        end
        upd_rise  = upd_alarm & ~alarm_q;
        upd_total = (upd_rise && (total_q != 16'hFFFF)) ? total_q + 16'd1 : total_q;
    end

    always_comb begin
        state_d       = state_q;
        sample_d      = sample_q;
        have_sample_d = have_sample_q;
        ewma_d        = ewma_q;
        snap_d        = snap_q;
        snap_ok_d     = snap_ok_q;
        baseline_d    = baseline_q;
        dev_d         = dev_q;
        warm_d        = warm_q;
        out_run_d     = out_run_q;
        in_run_d      = in_run_q;
        alarm_d       = alarm_q;
        total_d       = total_q;
        overrun_d     = overrun_q;
        outlier_d     = outlier_q;
        deviation_d   = deviation_q;

        if (sample_valid) begin
            sample_d      = rssi;
            have_sample_d = 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                if (EnableDecision) begin
                    ewma_d        = ewma_rssi;
                    snap_d        = sample_q;
                    snap_ok_d     = have_sample_q;
                    have_sample_d = sample_valid;
                    state_d       = CMP;
                end
            end
            CMP: begin
                dev_d      = diff_w;
                baseline_d = ewma_q;
                state_d    = UPD;
                if (EnableDecision) overrun_d = 1'b1;
            end
            UPD: begin
                state_d = IDLE;
                if (EnableDecision) overrun_d = 1'b1;
                if (!warm_done) begin
                    warm_d = warm_q + WW'(1);
                end else if (snap_ok_q) begin
                    outlier_d   = upd_outlier;
                    deviation_d = dev_q;
                    out_run_d   = upd_out_run;
                    in_run_d    = upd_in_run;
                    alarm_d     = upd_alarm;
                    total_d     = upd_total;
                end
            end
            default: state_d = IDLE;
        endcase

        // Clear wins over a same-cycle update but leaves the FSM and baseline alone.
        if (clear) begin
            alarm_d   = 1'b0;
            out_run_d = '0;
            in_run_d  = '0;
            total_d   = '0;
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge clk_h or negedge rst_h) begin
        if (!rst_h) begin
            state_q       <= IDLE;
            sample_q      <= '0;
            have_sample_q <= 1'b0;
            ewma_q        <= '0;
            snap_q        <= '0;
            snap_ok_q     <= 1'b0;
            baseline_q    <= '0;
            dev_q         <= '0;
            warm_q        <= '0;
            out_run_q     <= '0;
            in_run_q      <= '0;
            alarm_q       <= 1'b0;
            total_q       <= '0;
            overrun_q     <= 1'b0;
            outlier_q     <= 1'b0;
            deviation_q   <= '0;
        end else begin
            state_q       <= state_d;
            sample_q      <= sample_d;
            have_sample_q <= have_sample_d;
            ewma_q        <= ewma_d;
            snap_q        <= snap_d;
            snap_ok_q     <= snap_ok_d;
            baseline_q    <= baseline_d;
            dev_q         <= dev_d;
            warm_q        <= warm_d;
            out_run_q     <= out_run_d;
            in_run_q      <= in_run_d;
            alarm_q       <= alarm_d;
            total_q       <= total_d;
            overrun_q     <= overrun_d;
            outlier_q     <= outlier_d;
            deviation_q   <= deviation_d;
        end
    end

    // Outputs show the fresh result during the UPD cycle and hold it afterwards.
    assign decision_valid = dec_now;
    assign outlier        = dec_now ? upd_outlier : outlier_q;
    assign deviation      = dec_now ? dev_q : deviation_q;
    assign alarm          = dec_now ? upd_alarm : alarm_q;
    assign alarm_pulse    = dec_now & upd_rise;
    assign alarm_total    = dec_now ? upd_total : total_q;
    assign overrun        = overrun_q;

endmodule

// File: tb/tb_rssi_anomaly_decision.sv
// Randomized bench for rssi_anomaly_decision against a transaction-level reference model.
module tb_rssi_anomaly_decision;

    localparam int WARMUP = 4;

    logic        clk_h = 1'b0;
    logic        rst_h = 1'b0;
    logic        sample_valid = 1'b0;
    logic [31:0] rssi = '0;
    logic        EnableDecision = 1'b0;
    logic [31:0] ewma_rssi = '0;
    logic        clear = 1'b0;
    logic        decision_valid;
    logic        outlier;
    logic [31:0] deviation;
    logic        alarm;
    logic        alarm_pulse;
    logic [15:0] alarm_total;
    logic        overrun;

    rssi_anomaly_decision dut (
        .clk_h          (clk_h),
        .rst_h          (rst_h),
        .sample_valid   (sample_valid),
        .rssi           (rssi),
        .EnableDecision (EnableDecision),
        .ewma_rssi      (ewma_rssi),
        .clear          (clear),
        .decision_valid (decision_valid),
        .outlier        (outlier),
        .deviation      (deviation),
        .alarm          (alarm),
        .alarm_pulse    (alarm_pulse),
        .alarm_total    (alarm_total),
        .overrun        (overrun)
    );

    always #5 clk_h = ~clk_h;

    int n_checks = 0;
    int n_errors = 0;
    int n_dec    = 0;

    // Reference model state: one entry per decision transaction, plain integers.
    logic [31:0] m_base, m_sample, m_last_dev;
    bit          m_have, m_alarm, m_overrun, m_last_out;
    int          m_warm, m_cons_out, m_cons_in, m_total;

    logic [31:0] obs_dev;
    logic        obs_out;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_h);
        #1;
    endtask

    function automatic longint sm2i(input logic [31:0] v);
        longint mag;
        mag = longint'(v[30:0]);
        return v[31] ? -mag : mag;
    endfunction

    function automatic logic [31:0] exp_dev(input logic [31:0] s, input logic [31:0] b);
        longint d, m;
        d = sm2i(s) - sm2i(b);
        m = (d < 0) ? -d : d;
        if (m > 64'sh7FFF_FFFF) m = 64'sh7FFF_FFFF;
        return {(d < 0), m[30:0]};
    endfunction

    task automatic model_reset();
        m_base = '0; m_sample = '0; m_last_dev = '0;
        m_have = 0; m_alarm = 0; m_overrun = 0; m_last_out = 0;
        m_warm = 0; m_cons_out = 0; m_cons_in = 0; m_total = 0;
    endtask

    task automatic run_decision(input bit with_s, input logic [31:0] s,
                                input logic [31:0] e, input bit dbl);
        logic [31:0] snap, old_base, dev;
        bit ok, exp_dv, outl, rise;
        exp_dv = 0; rise = 0;
        if (with_s) begin
            m_sample = s;
            m_have   = 1;
        end
        snap = m_sample; ok = m_have; m_have = 0;
        old_base = m_base; m_base = e;
        if (dbl) m_overrun = 1;
        if (m_warm < WARMUP) begin
            m_warm++;
        end else if (ok) begin
            exp_dv = 1;
            dev  = exp_dev(snap, old_base);
            outl = (dev[30:0] > 31'd20);
            m_last_dev = dev;
            m_last_out = outl;
            if (outl) begin
                m_cons_out++;
                m_cons_in = 0;
                if (!m_alarm && m_cons_out >= 3) begin
                    m_alarm = 1;
                    rise = 1;
                    if (m_total < 65535) m_total++;
                end
            end else begin
                m_cons_in++;
                m_cons_out = 0;
                if (m_alarm && m_cons_in >= 8) m_alarm = 0;
            end
        end

        if (with_s) begin
            sample_valid = 1'b1;
            rssi = s;
            tick();
            sample_valid = 1'b0;
        end
        EnableDecision = 1'b1;
        ewma_rssi = e;
        tick();
        if (!dbl) EnableDecision = 1'b0;
        @(negedge clk_h);
        check_eq("dv_n1", decision_valid, 0);
        tick();
        EnableDecision = 1'b0;
        @(negedge clk_h);
        obs_dev = deviation;
        obs_out = outlier;
        check_eq("dv_n2", decision_valid, exp_dv);
        check_eq("outlier", outlier, m_last_out);
        check_eq("deviation", deviation, m_last_dev);
        check_eq("alarm", alarm, m_alarm);
        check_eq("alarm_pulse", alarm_pulse, rise);
        check_eq("alarm_total", alarm_total, m_total);
        check_eq("overrun", overrun, m_overrun);
        $display("dec %0d: smp=%0b s=%08h e=%08h dbl=%0b dv=%0b dev=%08h out=%0b alarm=%0b total=%0d",
                 n_dec, with_s, s, e, dbl, decision_valid, deviation, outlier, alarm, alarm_total);
        n_dec++;
        tick();
        @(negedge clk_h);
        check_eq("dv_n3", decision_valid, 0);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        m_alarm = 0; m_cons_out = 0; m_cons_in = 0; m_total = 0; m_overrun = 0;
        @(negedge clk_h);
        check_eq("clr_alarm", alarm, 0);
        check_eq("clr_total", alarm_total, 0);
        check_eq("clr_overrun", overrun, 0);
        check_eq("clr_pulse", alarm_pulse, 0);
        $display("clear: alarm=%0b total=%0d overrun=%0b", alarm, alarm_total, overrun);
    endtask

    function automatic logic [31:0] near(input int lo, input int hi);
        logic sgn;
        sgn = 1'($urandom_range(0, 1));
        return {sgn, 31'($urandom_range(lo, hi))};
    endfunction

    initial begin
        model_reset();
        repeat (3) tick();
        @(negedge clk_h);
        check_eq("rst_dv", decision_valid, 0);
        check_eq("rst_outlier", outlier, 0);
        check_eq("rst_deviation", deviation, 0);
        check_eq("rst_alarm", alarm, 0);
        check_eq("rst_pulse", alarm_pulse, 0);
        check_eq("rst_total", alarm_total, 0);
        check_eq("rst_overrun", overrun, 0);
        rst_h = 1'b1;
        tick();

        // Warm-up: four decisions only load the baseline.
        for (int i = 0; i < 3; i++) run_decision(1, $urandom, $urandom, 0);
        run_decision(1, $urandom, 32'd50, 0);

        run_decision(1, 32'd55, 32'd50, 0);
        check_eq("first_dev5", obs_dev, 32'd5);
        check_eq("first_inlier", obs_out, 0);

        for (int i = 0; i < 3; i++) run_decision(1, 32'd80, 32'd50, 0);
        check_eq("alarm_set", alarm, 1);
        check_eq("alarm_total1", alarm_total, 16'd1);

        for (int i = 0; i < 7; i++) run_decision(1, {1'b0, 31'($urandom_range(30, 70))}, 32'd50, 0);
        check_eq("alarm_hold7", alarm, 1);
        run_decision(1, 32'd50, 32'd50, 0);
        check_eq("alarm_clear8", alarm, 0);
        for (int i = 0; i < 9; i++) run_decision(1, 32'h8000_0064, 32'd50, 0);
        check_eq("alarm_total2", alarm_total, 16'd2);

        // Sign-magnitude corners.
        run_decision(1, $urandom, 32'h8000_001E, 0);
        run_decision(1, 32'h0000_0005, 32'h0, 0);
        check_eq("dev_plus35", obs_dev, 32'h0000_0023);
        check_eq("out_plus35", obs_out, 1);
        run_decision(1, 32'h8000_0000, 32'h7FFF_FFFF, 0);
        check_eq("dev_negzero", obs_dev, 32'h0);
        check_eq("out_negzero", obs_out, 0);
        run_decision(1, 32'hFFFF_FFFF, 32'd50, 0);
        check_eq("dev_sat", obs_dev, 32'hFFFF_FFFF);
        check_eq("out_sat", obs_out, 1);

        // Back-to-back EnableDecision, then clear, then a decision without a fresh sample.
        run_decision(1, 32'd52, 32'd50, 1);
        check_eq("overrun_set", overrun, 1);
        do_clear();
        run_decision(0, 32'h0, 32'd100, 0);
        run_decision(1, 32'd100, 32'd50, 0);
        check_eq("nosmp_base", obs_dev, 32'h0);

        for (int i = 0; i < 40; i++) begin
            bit ws, db;
            logic [31:0] s, e;
            ws = ($urandom_range(0, 3) != 0);
            db = ($urandom_range(0, 9) == 0);
            s  = ($urandom_range(0, 4) == 0) ? $urandom : near(10, 90);
            e  = ($urandom_range(0, 7) == 0) ? $urandom : {1'b0, 31'($urandom_range(40, 60))};
            run_decision(ws, s, e, db);
            if ($urandom_range(0, 11) == 0) do_clear();
        end

        // Reset while a decision is in flight: it must be lost.
        sample_valid = 1'b1; rssi = 32'd500; tick(); sample_valid = 1'b0;
        EnableDecision = 1'b1; ewma_rssi = 32'd10; tick(); EnableDecision = 1'b0;
        rst_h = 1'b0;
        #2;
        check_eq("midrst_dv", decision_valid, 0);
        check_eq("midrst_alarm", alarm, 0);
        check_eq("midrst_total", alarm_total, 0);
        check_eq("midrst_dev", deviation, 0);
        check_eq("midrst_overrun", overrun, 0);
        tick();
        tick();
        rst_h = 1'b1;
        model_reset();
        tick();
        run_decision(1, 32'd900, 32'd10, 0);
        for (int i = 0; i < 6; i++) run_decision(1, near(0, 60), {1'b0, 31'($urandom_range(0, 40))}, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
